// File: rtl/pipe_add_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
package pipe_add_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  localparam int MAX_STAGES = 4;

  // Index of the chunk that holds a given bit for a chunk width cw.
  function automatic int chunk_idx(input int bit_pos, input int cw);
    return bit_pos / cw;
  endfunction

endpackage

// File: rtl/pipe_add_sub_add_slice.sv
// One CW-bit ripple slice: chunk sum, carry-out and carry into the chunk MSB.
module add_slice
  import pipe_add_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic [CW-1:0] a_i,
  input  logic [CW-1:0] b_i,
  input  logic          c_i,
  output logic [CW-1:0] s_o,
  output logic          c_o,
  output logic          cmsb_o
);

  logic [CW:0] full;

  assign full   = {1'b0, a_i} + {1'b0, b_i} + {{CW{1'b0}}, c_i};
  assign s_o    = full[CW-1:0];
  assign c_o    = full[CW];
  // Recover the carry into the MSB from the MSB sum bit and its operands.
  assign cmsb_o = a_i[CW-1] ^ b_i[CW-1] ^ s_o[CW-1];

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined add/sub: one CW-bit chunk per stage, carry registered between stages.
// Optional saturating mode enabled by defining PIPE_ADD_SAT_EN (adds the sat input).
module pipe_add_sub
  import pipe_add_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPE_ADD_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW  = WIDTH / STAGES;
  localparam int TOP = chunk_idx(WIDTH - 1, CW);

`ifdef PIPE_ADD_SAT_EN
  // Positive overflow wraps to a negative MSB; clamp toward the matching rail.
  function automatic logic [WIDTH-1:0] sat_clamp(input logic [WIDTH-1:0] s);
    return {~s[WIDTH-1], {(WIDTH-1){s[WIDTH-1]}}};
  endfunction
`endif

  logic             adv;
  logic [STAGES-1:0] vld_q, vld_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q, zero_q;

  // Whole pipe advances together; bubbles are carried, not squeezed out.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = in_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q <= vld_d;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_in, b_in, s_in, s_d;
    logic             c_in, z_in, z_d;
    logic [CW-1:0]    cs;
    logic             co, cm;
    logic             unused_ops;
`ifdef PIPE_ADD_SAT_EN
    logic             sat_in;
`endif

    // ---- stage k input: formed operands (k==0) or previous stage registers
    if (k == 0) begin : g_form
      assign a_in = a;
      assign b_in = (op == OP_SUB) ? ~b : b;
      assign c_in = (op == OP_SUB) ? ~cin : cin;
      assign s_in = '0;
      assign z_in = 1'b1;
`ifdef PIPE_ADD_SAT_EN
      assign sat_in = sat;
`endif
    end else begin : g_chain
      assign a_in = g_stage[k-1].g_mid.a_q;
      assign b_in = g_stage[k-1].g_mid.b_q;
      assign s_in = g_stage[k-1].g_mid.s_q;
      assign c_in = g_stage[k-1].g_mid.c_q;
      assign z_in = g_stage[k-1].g_mid.z_q;
`ifdef PIPE_ADD_SAT_EN
      assign sat_in = g_stage[k-1].g_mid.sat_q;
`endif
    end

    add_slice #(.CW(CW)) u_slice (
      .a_i    (a_in[k*CW +: CW]),
      .b_i    (b_in[k*CW +: CW]),
      .c_i    (c_in),
      .s_o    (cs),
      .c_o    (co),
      .cmsb_o (cm)
    );

    always_comb begin
      s_d              = s_in;
      s_d[k*CW +: CW]  = cs;
    end

    assign z_d        = z_in & (cs == '0);
    assign unused_ops = ^{a_in, b_in, cm};

    if (k < TOP) begin : g_mid
      logic [WIDTH-1:0] a_q, b_q, s_q;
      logic             c_q, z_q;
`ifdef PIPE_ADD_SAT_EN
      logic             sat_q;
`endif

      // ---- stage k -> k+1 boundary
      always_ff @(posedge clk) begin
        if (adv) begin
          a_q <= a_in;
          b_q <= b_in;
          s_q <= s_d;
          c_q <= co;
          z_q <= z_d;
`ifdef PIPE_ADD_SAT_EN
          sat_q <= sat_in;
`endif
        end
      end
    end else begin : g_last
      logic [WIDTH-1:0] sum_d;
      logic             ovf_d, zero_d;

      assign ovf_d = cm ^ co;
`ifdef PIPE_ADD_SAT_EN
      logic sat_hit;
      assign sat_hit = sat_in & ovf_d;
      assign sum_d   = sat_hit ? sat_clamp(s_d) : s_d;
      // A clamped value is a rail, never zero.
      assign zero_d  = sat_hit ? 1'b0 : z_d;
`else
      assign sum_d   = s_d;
      assign zero_d  = z_d;
`endif

      // ---- final stage boundary: result and flags
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_q  <= '0;
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv) begin
          sum_q  <= sum_d;
          cout_q <= co;
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
        end
      end
    end
  end

  assign out_valid = vld_q[TOP];
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipe_add_sub.sv
// Directed bench for pipe_add_sub (WIDTH=32, STAGES=2), table vectors plus stream/stall/reset sequences.
module tb_pipe_add_sub;
  import pipe_add_pkg::*;

  localparam int W  = 32;
  localparam int ST = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  op_t          op = OP_ADD;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
`ifdef PIPE_ADD_SAT_EN
  logic         sat = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout, ovf, zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    op_t          op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sat;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    logic         z;
  } vec_t;

  vec_t tbl[13];

  always #5 clk = ~clk;

  pipe_add_sub #(.WIDTH(W), .STAGES(ST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef PIPE_ADD_SAT_EN
    .sat       (sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  task automatic apply_vec(input int idx);
    vec_t v;
    v = tbl[idx];
    @(negedge clk);
    in_valid = 1'b1;
    op  = v.op;
    a   = v.a;
    b   = v.b;
    cin = v.cin;
`ifdef PIPE_ADD_SAT_EN
    sat = v.sat;
`endif
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk1($sformatf("v%0d_early_valid", idx), out_valid, 1'b0);
    @(negedge clk);
    #1;
    chk1($sformatf("v%0d_valid", idx), out_valid, 1'b1);
    chk ($sformatf("v%0d_sum", idx), sum, v.s);
    chk1($sformatf("v%0d_cout", idx), cout, v.co);
    chk1($sformatf("v%0d_ovf", idx), ovf, v.ov);
    chk1($sformatf("v%0d_zero", idx), zero, v.z);
  endtask

  // Streams n ADDs; out_ready is dropped on cycles st_lo..st_hi (pass st_lo<0 for none).
  task automatic run_stream(input int n, input int st_lo, input int st_hi, input string tag);
    logic [W-1:0] expq[$];
    logic [W-1:0] held;
    int sent, got, first, last;
    bit ready_always;
    sent = 0; got = 0; first = -1; last = -1; ready_always = 1'b1; held = '0;
    for (int cyc = 0; cyc < n + 20 && got < n; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= st_lo && cyc <= st_hi);
      in_valid  = (sent < n);
      op  = OP_ADD;
      cin = 1'b0;
`ifdef PIPE_ADD_SAT_EN
      sat = 1'b0;
`endif
      a = 32'(sent) * 32'h0101_0101 + 32'h0000_FFFF;
      b = 32'(sent + 1);
      #1;
      if (cyc >= st_lo && cyc <= st_hi) begin
        if (cyc == st_lo) held = sum;
        chk1({tag, "_stall_in_ready"}, in_ready, 1'b0);
        chk1({tag, "_stall_valid"}, out_valid, 1'b1);
        if (cyc > st_lo) chk({tag, "_stall_sum_stable"}, sum, held);
      end
      if (st_lo < 0 && !in_ready) ready_always = 1'b0;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk1({tag, "_extra_result"}, out_valid, 1'b0);
        end else begin
          chk({tag, "_sum"}, sum, expq.pop_front());
        end
        got++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (in_valid && in_ready) begin
        expq.push_back(a + b);
        sent++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk({tag, "_count"}, 32'(got), 32'(n));
    chk({tag, "_leftover"}, 32'(expq.size()), 32'd0);
    if (st_lo < 0) begin
      chk({tag, "_consecutive"}, 32'(last - first), 32'(n - 1));
      chk1({tag, "_in_ready_const"}, ready_always, 1'b1);
    end
    repeat (3) begin
      @(negedge clk);
      #1;
      chk1({tag, "_drain_idle"}, out_valid, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{OP_ADD, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{OP_SUB, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
`ifdef PIPE_ADD_SAT_EN
    tbl[4]  = '{OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
`else
    tbl[4]  = '{OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
`endif
    tbl[6]  = '{OP_SUB, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{OP_ADD, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 32'h0000_0004, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{OP_SUB, 32'h0000_000A, 32'h0000_0003, 1'b1, 1'b0, 32'h0000_0006, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{OP_ADD, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{OP_ADD, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{OP_SUB, 32'h0001_0000, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_FFFF, 1'b1, 1'b0, 1'b0};

    // Reset state
    #12;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk ("rst_sum", sum, 32'h0);
    chk1("rst_cout", cout, 1'b0);
    chk1("rst_ovf", ovf, 1'b0);
    chk1("rst_zero", zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk1("rst_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 13; i++) apply_vec(i);

    run_stream(8, -1, -2, "stream");
    run_stream(10, 4, 6, "stall");

    // Reset with two operations in flight
    @(negedge clk);
    in_valid = 1'b1;
    op = OP_ADD; cin = 1'b0;
    a = 32'h1111_1111; b = 32'h2222_2222;
    @(negedge clk);
    a = 32'h0000_0001; b = 32'h0000_0002;
    @(posedge clk);
    #2;
    chk1("midrst_pre_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk ("midrst_sum", sum, 32'h0);
    chk1("midrst_cout", cout, 1'b0);
    chk1("midrst_ovf", ovf, 1'b0);
    chk1("midrst_zero", zero, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk1("midrst_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk1("midrst_no_stale", out_valid, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_add_sub.md
Name: pipe_add_sub

Overview:
- Parametrised, pipelined adder/subtractor; successor to the single-cycle combinational adder in the MIPS datapath.
- Splits the operand width into STAGES equal chunks; one chunk is added per cycle, and the carry ripples through registers between stages.
- Adds carry-in, subtract mode, status flags, and a valid/ready handshake so the EX stage can stall it.
- Used for the ALU add path and branch-target adder when timing requires multi-cycle add.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 2, pipeline depth and chunk count; legal values 1..4.
- CW, WIDTH/STAGES, chunk width; derived localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands this cycle.
- op  in  1  0 = ADD, 1 = SUB (op_t from package).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (ADD) / borrow-in (SUB).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out (ADD) / not-borrow (SUB).
- ovf  out  1  signed two's-complement overflow.
- zero  out  1  sum == 0.

Behaviour:
- Reset is asynchronous with rst_n low:
  - All stage valid bits clear.
  - sum, cout, ovf and zero are 0; out_valid is 0.
  - in_ready is 1 after reset deasserts.
  - An operation in flight when reset asserts is discarded with no output.
- Operand formation:
  - ADD computes a + b + cin.
  - SUB computes a + ~b + ~cin, i.e. a - b - cin.
  - Conversion happens at the input register; op is not carried further.
- Stage k (0..STAGES-1) adds chunk k of A' and B' plus the registered carry from stage k-1.
  - Stage 0 uses the formed carry-in.
  - Upper chunks not yet consumed travel down skew registers.
  - Lower result chunks travel down de-skew registers.
- Latency: exactly STAGES cycles from an accepted input (in_valid & in_ready) to out_valid, when not stalled.
- Throughput: one operation per cycle.
- Global advance enable: adv = out_ready | ~out_valid.
  - in_ready = adv.
  - All stage registers load only when adv is 1.
  - Internal bubbles are not collapsed.
- Stall: while out_valid=1 and out_ready=0, every register holds and sum/flags stay stable.
- Simultaneous accept and output on the same cycle is legal, giving full throughput.
- Flags are registered with sum:
  - cout is the carry from the top chunk.
  - ovf = carry-into-MSB XOR carry-out-of-MSB.
  - zero: each stage ANDs a running zero flag with (chunk result == 0).
- Wrap-around: the result is modulo 2^WIDTH, for example 0xFFFFFFFF + 1 gives sum 0 with cout = 1.
- STAGES=1 degenerates to a single registered adder with latency 1.

Optional Feature:
- Macro: PIPE_ADD_SAT_EN.
- When defined, an input sat (1 bit) is added and registered alongside each operation.
  - If sat=1 and ovf=1, sum clamps to 0x7FFF..F on positive overflow or 0x8000..0 on negative overflow.
  - ovf still reports 1; zero is evaluated on the clamped value.
  - Clamping happens in the final stage and adds no latency.
- When undefined, there is no sat port and the result always wraps.

Decomposition:
- Package pipe_add_pkg holds:
  - typedef enum logic {OP_ADD, OP_SUB} op_t;
  - constant MAX_STAGES = 4;
  - helper function chunk_idx.
- Sub-module add_slice: combinational CW-bit adder with cin; outputs chunk sum, cout, and carry-into-MSB.
  - Instantiated STAGES times via generate.
  - Carry-into-MSB is used only in the top slice.

Test Plan (WIDTH=32, STAGES=2):
- ADD a=0x0000FFFF, b=0x00000001, cin=0: the inter-chunk carry crosses the stage boundary -> after 2 cycles sum=0x00010000, cout=0, ovf=0, zero=0.
- SUB a=5, b=5, cin=0 -> sum=0, zero=1, cout=1; ADD 0xFFFFFFFF+1 -> sum=0, cout=1, zero=1.
- ADD 0x7FFFFFFF+1 -> sum=0x80000000, ovf=1; with PIPE_ADD_SAT_EN and sat=1 -> sum=0x7FFFFFFF, ovf=1.
- Back-to-back stream of 8 ADDs with out_ready held 1 -> 8 results on consecutive cycles in order, in_ready constantly 1.
- Hold out_ready=0 for 3 cycles while a result is valid -> sum stable, in_ready=0, no input accepted; release -> stream resumes with no loss or duplication.
- Assert rst_n=0 mid-flight with 2 ops pending -> out_valid=0 immediately, all outputs 0, no stale result after rst_n rises.
